// File: rtl/pc_fetch.sv
// Fetch stage: owns the program counter, fetches each instruction over a
// req/ack handshake, presents it to decode/execute and selects the next PC
// from the downstream branch decision.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_src,
  input  logic [15:0] br_offset,
  input  logic [25:0] j_target,
  input  logic [31:0] jr_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        addr_err,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] next_pc;
  logic [31:0] br_disp;
  logic        jr_misaligned;
  logic        exec_done;

  assign imem_addr     = pc;
  assign pc_plus4      = pc + 32'd4;
  assign br_disp       = {{14{br_offset[15]}}, br_offset, 2'b00};
  assign jr_misaligned = (pc_src == 2'b11) && (jr_addr[1:0] != 2'b00);
  assign exec_done     = (state == EXEC) && !stall;

  // Next-PC mux driven by the branch decision.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = {pc_plus4[31:28], j_target, 2'b00};
      2'b10: next_pc = pc_plus4 + br_disp;
      2'b11: next_pc = {jr_addr[31:2], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  // Next-state logic for the IDLE -> FETCH <-> EXEC cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (imem_ack) state_nxt = EXEC;
      EXEC:    if (!stall) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers: PC, latched instruction, handshake, error pulse, counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
      retired     <= '0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        IDLE: imem_req <= 1'b1;
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
          end
        end
        EXEC: begin
          if (exec_done) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            retired     <= retired + 32'd1;
            imem_req    <= 1'b1;
            addr_err    <= jr_misaligned;
          end
        end
        default: imem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a table of single-instruction steps chained
// through the PC, followed by ack-delay, stall and reset sequences.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic [15:0] br_offset;
  logic [25:0] j_target;
  logic [31:0] jr_addr;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .br_offset(br_offset),
    .j_target(j_target), .jr_addr(jr_addr), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .addr_err(addr_err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src;
    logic [15:0] off;
    logic [25:0] jt;
    logic [31:0] jra;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction starting in FETCH: ack immediately, then execute with stall=0.
  task automatic run_instr(input vec_t v, input logic [31:0] cur_pc, input logic [31:0] word);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, cur_pc);
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("exec_instr", instr, word);
    chk("exec_req", {31'd0, imem_req}, 32'd0);
    chk("exec_pc4", pc_plus4, cur_pc + 32'd4);
    chk("err_cleared", {31'd0, addr_err}, 32'd0);
    pc_src = v.src; br_offset = v.off; j_target = v.jt; jr_addr = v.jra; stall = 1'b0;
    tick();
    chk("next_pc", pc, v.exp_pc);
    chk("addr_err", {31'd0, addr_err}, {31'd0, v.exp_err});
    chk("valid_drop", {31'd0, instr_valid}, 32'd0);
    pc_src = 2'b00; jr_addr = 32'd0;
  endtask

  initial begin
    logic [31:0] cur;
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    logic [31:0] base_ret;

    vecs[0]  = '{2'b00, 16'h0000, 26'h0, 32'h0,         32'h0000_0004, 1'b0};
    vecs[1]  = '{2'b00, 16'h0000, 26'h0, 32'h0,         32'h0000_0008, 1'b0};
    vecs[2]  = '{2'b00, 16'h0000, 26'h0, 32'h0,         32'h0000_000C, 1'b0};
    vecs[3]  = '{2'b11, 16'h0000, 26'h0, 32'h0000_0100, 32'h0000_0100, 1'b0};
    vecs[4]  = '{2'b10, 16'hFFFE, 26'h0, 32'h0,         32'h0000_00FC, 1'b0};
    vecs[5]  = '{2'b11, 16'h0000, 26'h0, 32'h0000_0100, 32'h0000_0100, 1'b0};
    vecs[6]  = '{2'b10, 16'h0003, 26'h0, 32'h0,         32'h0000_0110, 1'b0};
    vecs[7]  = '{2'b11, 16'h0000, 26'h0, 32'h1000_0040, 32'h1000_0040, 1'b0};
    vecs[8]  = '{2'b01, 16'h0000, 26'h123, 32'h0,       32'h1000_048C, 1'b0};
    vecs[9]  = '{2'b11, 16'h0000, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    vecs[10] = '{2'b00, 16'h0000, 26'h0, 32'h0,         32'h0000_0000, 1'b0};
    vecs[11] = '{2'b11, 16'h0000, 26'h0, 32'h0000_2003, 32'h0000_2000, 1'b1};
    vecs[12] = '{2'b11, 16'h0000, 26'h0, 32'h0000_2000, 32'h0000_2000, 1'b0};

    rst_n = 1'b0; pc_src = 2'b00; br_offset = '0; j_target = '0; jr_addr = '0;
    stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);

    rst_n = 1'b1;
    tick();
    cur = 32'h0;
    for (int i = 0; i < 13; i++) begin
      run_instr(vecs[i], cur, 32'hA000_0000 + i);
      cur = vecs[i].exp_pc;
    end
    chk("retired_13", retired, 32'd13);

    // Ack delayed by 3 cycles: request and address must hold steady.
    base_ret = retired;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h0000_2000);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("late_instr", instr, 32'hDEAD_BEEF);
    held_pc = pc; held_instr = instr;

    // Stall for 4 cycles while pc_src toggles; nothing may move.
    stall = 1'b1;
    jr_addr = 32'h0000_3001; br_offset = 16'h0010; j_target = 26'h3FF;
    for (int i = 0; i < 4; i++) begin
      pc_src = 2'(i);
      tick();
      chk("stall_pc", pc, held_pc);
      chk("stall_instr", instr, held_instr);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_err", {31'd0, addr_err}, 32'd0);
      chk("stall_ret", retired, base_ret);
    end
    stall = 1'b0; pc_src = 2'b00;
    tick();
    chk("release_pc", pc, held_pc + 32'd4);
    chk("release_ret", retired, base_ret + 32'd1);
    chk("release_err", {31'd0, addr_err}, 32'd0);
    chk("release_req", {31'd0, imem_req}, 32'd1);

    // Reset while in FETCH with a request outstanding.
    rst_n = 1'b0;
    tick();
    chk("midfetch_req", {31'd0, imem_req}, 32'd0);
    chk("midfetch_pc", pc, 32'h0);
    chk("midfetch_ret", retired, 32'd0);
    chk("midfetch_instr", instr, 32'h0);
    chk("midfetch_valid", {31'd0, instr_valid}, 32'd0);

    // Ack arriving in IDLE must be ignored.
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    chk("idle_ack_instr", instr, 32'h0);
    chk("idle_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle_ack_req", {31'd0, imem_req}, 32'd1);

    // Reset while in EXEC.
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    tick();
    imem_ack = 1'b0;
    chk("exec_again_valid", {31'd0, instr_valid}, 32'd1);
    stall = 1'b1; rst_n = 1'b0;
    tick();
    stall = 1'b0; rst_n = 1'b1;
    chk("midexec_instr", instr, 32'h0);
    chk("midexec_valid", {31'd0, instr_valid}, 32'd0);
    chk("midexec_pc", pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Fetch stage: holds the program counter, requests instructions from instruction memory over a req/ack handshake, and presents each instruction to decode/execute.
- Computes the next PC from the 2-bit pc_src code produced by the downstream branch-decision logic (00=PC+4, 01=jump, 10=branch, 11=jump-register).
- Sits between instruction memory and decode; closes the PC feedback loop.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
pc_src  input  2  next-PC select from branch decision: 00 PC+4, 01 j/jal, 10 taken branch, 11 jr/jalr
br_offset  input  16  branch immediate (instr[15:0]), signed word offset
j_target  input  26  jump index (instr[25:0])
jr_addr  input  32  register rs value for jr/jalr
stall  input  1  1 = downstream not ready, hold current instruction
imem_req  output  1  instruction memory request
imem_addr  output  32  request address (= pc)
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  fetched instruction word
instr  output  32  current instruction
instr_valid  output  1  instr is valid and pc_src/br_offset/j_target/jr_addr are being consumed
pc  output  32  address of current instruction
pc_plus4  output  32  pc + 4 (link value for jal/bal/jalr)
addr_err  output  1  one-cycle pulse: jr_addr not word-aligned
retired  output  32  count of instructions that completed EXEC

Behaviour:
- Reset (rst_n=0 at rising edge): pc=RESET_PC, state=IDLE, imem_req=0, instr=0, instr_valid=0, addr_err=0, retired=0. Any outstanding request is abandoned; an ack arriving during or after reset in IDLE is ignored.
- imem_addr = pc at all times (combinational). pc_plus4 = pc + 4, modulo 2^32 (combinational).
- FSM states: IDLE, FETCH, EXEC.
- IDLE: next edge -> FETCH, imem_req<=1.
- FETCH: imem_req held 1, imem_addr stable until ack. On edge with imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, -> EXEC. With imem_ack=0: remain, no change.
- EXEC: instr_valid=1; branch inputs are sampled only in this state. If stall=1: hold pc, instr, instr_valid; no request. If stall=0 at edge: pc<=next_pc, instr_valid<=0, retired<=retired+1 (wraps at 2^32), imem_req<=1, -> FETCH.
- imem_ack outside FETCH is ignored.
- next_pc, modulo 2^32:
  - 00: pc+4
  - 01: {pc_plus4[31:28], j_target, 2'b00}
  - 10: pc_plus4 + (sign_extend(br_offset) << 2)
  - 11: {jr_addr[31:2], 2'b00}
- addr_err: pulses 1 for exactly one cycle, registered at the EXEC-exit edge, when pc_src=11 and jr_addr[1:0]!=0. Otherwise 0.
- Throughput: minimum 2 cycles per instruction (ack in the first FETCH cycle, stall=0 in the first EXEC cycle). Each FETCH wait cycle or stall cycle adds 1.
- Simultaneous stall=1 with any pc_src: stall wins, and pc_src is re-evaluated each cycle until release. Only the value present on the releasing edge is used.
- Reset mid-FETCH or mid-EXEC: full return to reset values. Retired count is lost.

Test Plan:
- Reset, ack same cycle each fetch, pc_src=00 -> imem_addr sequence 0,4,8,C; instr_valid high every 2nd cycle; retired=4 after 8 cycles post-IDLE.
- pc=0x0000_0100, pc_src=10, br_offset=16'hFFFE -> next pc=0x0000_00FC. With br_offset=16'h0003 -> next pc=0x0000_0110.
- pc=0x1000_0040, pc_src=01, j_target=26'h0000_123 -> next pc=0x1000_048C. pc=0xFFFF_FFFC, pc_src=00 -> next pc wraps to 0x0000_0000.
- pc_src=11, jr_addr=0x0000_2003 -> next pc=0x0000_2000 and a single-cycle addr_err pulse. jr_addr=0x0000_2000 -> no pulse.
- FETCH with ack delayed 3 cycles -> imem_req and imem_addr stable throughout. Then stall=1 for 4 EXEC cycles with pc_src toggling, released with pc_src=00 -> pc advances by exactly 4, retired +1.
- rst_n=0 while in FETCH with imem_req=1 -> next cycle imem_req=0, pc=RESET_PC, retired=0. An ack arriving during IDLE leaves instr=0 and instr_valid=0.
